// File: rtl/note_event_queue.sv
// note_event_queue: turns per-key press/release pulses into an ordered
// event FIFO, parking edges in pending bits while the FIFO is full.
module note_event_queue #(
    parameter int NKEYS = 8,
    parameter int DEPTH = 4,
    parameter int IDXW  = 3
) (
    input  logic                     slow_clk,
    input  logic                     rst_n,
    input  logic [NKEYS-1:0]         key_pos,
    input  logic [NKEYS-1:0]         key_neg,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [IDXW-1:0]          evt_note,
    output logic                     evt_press,
    output logic [$clog2(DEPTH):0]   evt_count,
    input  logic                     clr_overflow,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [NKEYS-1:0] pend_p_q, pend_p_d;
    logic [NKEYS-1:0] pend_r_q, pend_r_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q;
    logic             ovf_q, ovf_d;
    logic [IDXW-1:0]  note_mem_q [DEPTH];
    logic             press_mem_q [DEPTH];

    logic             cand;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_press;
    logic             push, pop, lost;
    logic [NKEYS-1:0] onehot, clr_p, clr_r;

    // Pick the lowest-indexed key with anything pending; press before release.
    always_comb begin
        cand      = 1'b0;
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pend_p_q[i] | pend_r_q[i]) begin
                cand      = 1'b1;
                sel_idx   = IDXW'(i);
                sel_press = pend_p_q[i];
            end
        end
    end

    // Handshake, pending-bit bookkeeping, lost-edge detection and counters.
    always_comb begin
        pop    = valid_q & evt_ready;
        push   = cand & ((count_q != DEPTH_C) | pop);
        onehot = NKEYS'(1) << sel_idx;
        clr_p  = (push & sel_press)  ? onehot : '0;
        clr_r  = (push & ~sel_press) ? onehot : '0;
        // An edge on a bit that stays set this cycle has nowhere to go.
        lost   = (|(key_pos & pend_p_q & ~clr_p)) |
                 (|(key_neg & pend_r_q & ~clr_r));
        pend_p_d = (pend_p_q & ~clr_p) | key_pos;
        pend_r_d = (pend_r_q & ~clr_r) | key_neg;
        ovf_d    = (ovf_q & ~clr_overflow) | lost;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push & ~pop) begin
            count_d = count_q + CW'(1);
        end else if (pop & ~push) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset drops every stored and pending event.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p_q <= '0;
            pend_r_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pend_p_q <= pend_p_d;
            pend_r_q <= pend_r_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    // Event storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                note_mem_q[i]  <= '0;
                press_mem_q[i] <= 1'b0;
            end
        end else if (push) begin
            note_mem_q[wr_ptr_q]  <= sel_idx;
            press_mem_q[wr_ptr_q] <= sel_press;
        end
    end

    assign evt_valid = valid_q;
    assign evt_note  = note_mem_q[rd_ptr_q];
    assign evt_press = press_mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/note_event_queue.md
NOTE_EVENT_QUEUE -- requirements
Module: note_event_queue

Interface
REQ-001: Parameter NKEYS, default 8, number of debounced key channels.
REQ-002: Parameter DEPTH, default 4, FIFO depth in events; power of two, 2..16.
REQ-003: Parameter IDXW, default 3, note index width; 2^IDXW >= NKEYS.
REQ-004: slow_clk  input  1  clock; all state updates on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: key_pos  input  NKEYS  per-key one-cycle press pulse from debouncer stage.
REQ-007: key_neg  input  NKEYS  per-key one-cycle release pulse from debouncer stage.
REQ-008: evt_ready  input  1  consumer accepts head event.
REQ-009: evt_valid  output  1  head event available.
REQ-010: evt_note  output  IDXW  key index of head event.
REQ-011: evt_press  output  1  1 = press event, 0 = release event.
REQ-012: evt_count  output  clog2(DEPTH)+1  events currently stored.
REQ-013: clr_overflow  input  1  clears sticky overflow.
REQ-014: overflow  output  1  sticky; an edge was lost.

Function
REQ-015: Per key i, pend_p[i] SHALL set on a clock edge where key_pos[i]=1, and pend_r[i] SHALL set where key_neg[i]=1.
REQ-016: Each cycle, selector SHALL pick the lowest index i with pend_p[i] or pend_r[i]; if both set for that i, press SHALL be picked first.
REQ-017: Push SHALL occur when a candidate exists and (evt_count < DEPTH or pop occurs same cycle); a push clears the chosen pending bit.
REQ-018: At most one push and one pop per cycle.
REQ-019: Pop SHALL occur when evt_valid and evt_ready are both 1; no pop when FIFO is empty.
REQ-020: FIFO SHALL be show-ahead: evt_note/evt_press reflect the head entry whenever evt_valid=1; they are don't-care when evt_valid=0.
REQ-021: evt_valid SHALL equal (evt_count != 0), registered.
REQ-022: Simultaneous push and pop SHALL leave evt_count unchanged, including at count = DEPTH and count = 1.
REQ-023: Read/write pointers SHALL wrap modulo DEPTH.
REQ-024: Latency: key_pos[i] high in cycle N -> pending set at edge ending N -> push at next edge -> evt_valid=1 in cycle N+2 (FIFO empty, no higher-priority pending).
REQ-025: If an edge arrives on a pending bit that is already set and not being pushed that cycle, the edge SHALL be dropped and overflow set.
REQ-026: If an edge arrives on a pending bit that is being pushed that same cycle, the bit SHALL remain set (new event) and overflow SHALL NOT set.
REQ-027: Full FIFO SHALL NOT cause loss directly; events wait in pending bits.
REQ-028: clr_overflow SHALL clear overflow on the next edge; if set and clear coincide, set wins.
REQ-029: key_pos[i] and key_neg[i] both high in one cycle SHALL set both bits; press emitted before release.

Reset
REQ-030: rst_n low SHALL asynchronously clear all pending bits, pointers, evt_count=0, evt_valid=0, overflow=0.
REQ-031: Reset mid-operation SHALL discard all stored and pending events; first post-reset edge on key_pos/key_neg is treated as fresh.
REQ-032: evt_note and evt_press SHALL reset to 0.

Verification
REQ-033: Single press: key_pos[5] pulse in cycle 10, evt_ready=1 -> evt_valid=1 in cycle 12 with note=5, press=1; popped; count returns to 0.
REQ-034: Priority: key_pos[6], key_pos[2], key_neg[2] pulsed in one cycle, evt_ready=0 -> FIFO order (2,press), (2,release), (6,press); count=3; overflow=0.
REQ-035: Backpressure: evt_ready=0, presses on keys 0..5 (DEPTH=4) -> count=4 holds, keys 4,5 remain pending; assert evt_ready -> all 6 delivered in index order, overflow=0.
REQ-036: Overflow: evt_ready=0, FIFO full, key_pos[7] pulsed twice with 3 cycles between -> overflow=1, only one (7,press) delivered; clr_overflow pulse -> overflow=0.
REQ-037: Full push/pop: count=4, evt_ready=1 with pending key 3 -> count stays 4 for one cycle, (3,press) appended at tail.
REQ-038: Reset mid-stream: count=3 and key 1 pending, rst_n low one cycle -> evt_valid=0, count=0, overflow=0; no stale event after release.
